core_boot_loader: RTL

CORE_BOOT_LOADER -- requirements
Module: core_boot_loader

---
 rtl/core_pkg.sv | 41 ++++
 rtl/run_counter.sv | 35 +++
 rtl/core_boot_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared command opcodes, FSM state encoding and per-state control outputs
// for the core boot loader.
package core_pkg;

  typedef enum logic [1:0] {
    CMD_IMEM_WR = 2'b00,
    CMD_REG_WR  = 2'b01,
    CMD_START   = 2'b10,
    CMD_ABORT   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_SETUP = 2'b00,
    ST_ARM   = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef struct packed {
    logic setup;
    logic core_rst;
    logic cmd_ready;
    logic done;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{setup: 1'b1, core_rst: 1'b1, cmd_ready: 1'b0, done: 1'b0};

  // Control levels seen by the core while the FSM sits in a given state.
  function automatic ctrl_t state_ctrl(input state_e st);
    ctrl_t c;
    case (st)
      ST_SETUP: c = '{setup: 1'b1, core_rst: 1'b1, cmd_ready: 1'b1, done: 1'b0};
      ST_ARM:   c = '{setup: 1'b0, core_rst: 1'b1, cmd_ready: 1'b0, done: 1'b0};
      ST_RUN:   c = '{setup: 1'b0, core_rst: 1'b0, cmd_ready: 1'b1, done: 1'b0};
      ST_DONE:  c = '{setup: 1'b1, core_rst: 1'b1, cmd_ready: 1'b1, done: 1'b1};
      default:  c = CTRL_RESET;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/run_counter.sv
// Loadable down-counter for the run-cycle budget; saturates at zero and
// flags both zero and the final count of one.
module run_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count_r;

  // Budget register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});
  assign last  = (count_r == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/core_boot_loader.sv
// Boot loader: takes commands to fill instruction memory and preload registers,
// then releases the core for a bounded number of cycles.
module core_boot_loader
  import core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [XLEN-1:0]   cmd_addr,
  input  logic [XLEN-1:0]   cmd_data,
  output logic              imem_we,
  output logic [XLEN-1:0]   imem_addr,
  output logic [XLEN-1:0]   imem_data,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [XLEN-1:0]   reg_data,
  output logic              setup,
  output logic              core_rst,
  output logic [XLEN-1:0]   pc_start,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  cycles_left
);

  localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(4 * IMEM_DEPTH);

  state_e              state_r;
  state_e              next_state_s;
  ctrl_t               ctrl_r;
  ctrl_t               ctrl_s;
  cmd_op_e             op_s;
  logic                accept_s;
  logic                addr_ok_s;
  logic                reg_idx_nz_s;
  logic                imem_wr_s;
  logic                reg_wr_s;
  logic                start_s;
  logic                err_set_s;
  logic                cnt_dec_s;
  logic                cnt_zero_s;
  logic                cnt_last_s;
  logic                err_r;
  logic                imem_we_r;
  logic [XLEN-1:0]     imem_addr_r;
  logic [XLEN-1:0]     imem_data_r;
  logic                reg_we_r;
  logic [REG_AW-1:0]   reg_addr_r;
  logic [XLEN-1:0]     reg_data_r;
  logic [XLEN-1:0]     pc_start_r;

  assign op_s         = cmd_op_e'(cmd_op);
  assign accept_s     = cmd_valid & ctrl_r.cmd_ready;
  assign addr_ok_s    = (cmd_addr[1:0] == 2'b00) && (cmd_addr < IMEM_BYTES);
  assign reg_idx_nz_s = (cmd_addr[REG_AW-1:0] != {REG_AW{1'b0}});

  run_counter #(.W(CNT_W)) u_run_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (start_s),
    .load_val (cmd_data[CNT_W-1:0]),
    .dec      (cnt_dec_s),
    .count    (cycles_left),
    .zero     (cnt_zero_s),
    .last     (cnt_last_s)
  );

  // Next-state and command decode; control outputs are precomputed from the
  // next state so they can be registered alongside it.
  always_comb begin
    next_state_s = state_r;
    imem_wr_s    = 1'b0;
    reg_wr_s     = 1'b0;
    start_s      = 1'b0;
    err_set_s    = 1'b0;
    cnt_dec_s    = 1'b0;
    case (state_r)
      ST_SETUP, ST_DONE: begin
        if (accept_s) begin
          next_state_s = ST_SETUP;
          case (op_s)
            CMD_IMEM_WR: begin
              imem_wr_s = addr_ok_s;
              err_set_s = ~addr_ok_s;
            end
            CMD_REG_WR: reg_wr_s = reg_idx_nz_s;
            CMD_START: begin
              start_s      = 1'b1;
              next_state_s = ST_ARM;
            end
            CMD_ABORT: next_state_s = ST_SETUP;
            default:   next_state_s = ST_SETUP;
          endcase
        end else begin
          next_state_s = state_r;
        end
      end
      ST_ARM: begin
        if (cnt_zero_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_dec_s = 1'b1;
        // Anything but ABORT while the core runs is swallowed and flagged.
        err_set_s = accept_s && (op_s != CMD_ABORT);
        if (cnt_last_s || (accept_s && (op_s == CMD_ABORT))) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      default: next_state_s = ST_SETUP;
    endcase
    ctrl_s = state_ctrl(next_state_s);
  end

  // State, control outputs and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_SETUP;
      ctrl_r  <= CTRL_RESET;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= ctrl_s;
      err_r   <= err_r | err_set_s;
    end
  end

  // Write ports pulse for one cycle; address/data hold their last write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we_r   <= 1'b0;
      imem_addr_r <= {XLEN{1'b0}};
      imem_data_r <= {XLEN{1'b0}};
      reg_we_r    <= 1'b0;
      reg_addr_r  <= {REG_AW{1'b0}};
      reg_data_r  <= {XLEN{1'b0}};
    end else begin
      imem_we_r <= imem_wr_s;
      reg_we_r  <= reg_wr_s;
      if (imem_wr_s) begin
        imem_addr_r <= cmd_addr;
        imem_data_r <= cmd_data;
      end else begin
        imem_addr_r <= imem_addr_r;
        imem_data_r <= imem_data_r;
      end
      if (reg_wr_s) begin
        reg_addr_r <= cmd_addr[REG_AW-1:0];
        reg_data_r <= cmd_data;
      end else begin
        reg_addr_r <= reg_addr_r;
        reg_data_r <= reg_data_r;
      end
    end
  end

  // Start PC captured on an accepted START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_start_r <= {XLEN{1'b0}};
    end else if (start_s) begin
      pc_start_r <= cmd_addr;
    end else begin
      pc_start_r <= pc_start_r;
    end
  end

  assign cmd_ready = ctrl_r.cmd_ready;
  assign setup     = ctrl_r.setup;
  assign core_rst  = ctrl_r.core_rst;
  assign done      = ctrl_r.done;
  assign err       = err_r;
  assign imem_we   = imem_we_r;
  assign imem_addr = imem_addr_r;
  assign imem_data = imem_data_r;
  assign reg_we    = reg_we_r;
  assign reg_addr  = reg_addr_r;
  assign reg_data  = reg_data_r;
  assign pc_start  = pc_start_r;

endmodule
